// File: rtl/irq_req_latch8_if.sv
// Request/mask/ack bundle between the interrupt request latch and its consumer.
// The consumer (master) drives requests, mask writes and acks; the latch (slave) returns the presented vector.
interface irq_req_latch8_if #(
  parameter int DROP_W = 8
);
  logic [7:0]        req_in;
  logic              mask_we;
  logic [7:0]        mask_in;
  logic              ack;
  logic [2:0]        ack_idx;
  logic [7:0]        pend_vec;
  logic              irq_valid;
  logic              ack_err;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output req_in, mask_we, mask_in, ack, ack_idx,
    input  pend_vec, irq_valid, ack_err, drop_cnt
  );

  modport slave (
    input  req_in, mask_we, mask_in, ack, ack_idx,
    output pend_vec, irq_valid, ack_err, drop_cnt
  );
endinterface

// File: rtl/irq_req_latch8.sv
// Sticky 8-line interrupt request latch with software mask, valid/ack handshake and drop counter.
// Define REQ_EDGE_DETECT_EN to capture requests on rising edges instead of levels.
module irq_req_latch8 #(
  parameter logic [7:0] MASK_RST = 8'hFF,
  parameter int         DROP_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  irq_req_latch8_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VALID  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        pending_reg;
  logic [7:0]        pending_next;
  logic [7:0]        mask_reg;
  logic [7:0]        pend_vec;
  logic [7:0]        req_cap;
  logic [7:0]        clr_vec;
  logic [DROP_W-1:0] drop_cnt_reg;
  logic              ack_err_reg;
  logic              ack_legal;
  logic              ack_bad;
  logic              drop_any;
  logic              irq_valid;

`ifdef REQ_EDGE_DETECT_EN
  logic [7:0] req_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_reg <= '0;
    end else begin
      req_q_reg <= bus.req_in;
    end
  end

  assign req_cap = bus.req_in & ~req_q_reg;
`else
  assign req_cap = bus.req_in;
`endif

  assign pend_vec  = pending_reg & mask_reg;
  // Only an ack naming a presented bit while VALID is a real service.
  assign ack_legal = bus.ack && (state_reg == ST_VALID) && pend_vec[bus.ack_idx];
  assign ack_bad   = bus.ack && !ack_legal;

  // A set in the same cycle as its clear wins, so capture is ORed in after the clear.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign clr_vec[gi]      = ack_legal && (bus.ack_idx == 3'(gi));
      assign pending_next[gi] = req_cap[gi] | (pending_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  assign drop_any = |(req_cap & pending_reg & ~clr_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pend_vec != 8'h00) state_next = ST_VALID;
      end
      ST_VALID: begin
        if (ack_legal)                  state_next = ST_SETTLE;
        else if (pend_vec == 8'h00)     state_next = ST_IDLE;
      end
      ST_SETTLE: begin
        state_next = (pend_vec != 8'h00) ? ST_VALID : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_valid = 1'b0;
    if (state_reg == ST_VALID) irq_valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= '0;
      mask_reg     <= MASK_RST;
      ack_err_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      ack_err_reg <= ack_bad;
      if (bus.mask_we) begin
        mask_reg <= bus.mask_in;
      end
      // Multiple lines dropping together still count as one lost event.
      if (drop_any && (drop_cnt_reg != {DROP_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + {{(DROP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pend_vec  = pend_vec;
  assign bus.irq_valid = irq_valid;
  assign bus.ack_err   = ack_err_reg;
  assign bus.drop_cnt  = drop_cnt_reg;

endmodule

// File: doc/irq_req_latch8.md
Name: irq_req_latch8

Overview:
- Upstream companion to the 8-to-3 priority encoder.
- Captures eight asynchronous-to-service request lines into a sticky pending register and applies a software mask.
- Presents the masked vector to the encoder's 8-bit input.
- Runs a valid/ack handshake: the consumer returns the encoder's 3-bit index to clear the serviced bit.
- Counts requests that arrive while their bit is already pending.

Parameters:
- MASK_RST, 8'hFF, mask register value after reset (1 = line enabled).
- DROP_W, 8, width of the saturating dropped-request counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_in  in  8  request lines, bit 7 highest priority, sampled every clk.
- mask_we  in  1  load mask_in into the mask register this cycle.
- mask_in  in  8  new mask value.
- ack  in  1  consumer accepts the presented request.
- ack_idx  in  3  index of the serviced line (encoder output).
- pend_vec  out  8  pending & mask, drives the encoder input.
- irq_valid  out  1  at least one unmasked request is pending and presented.
- ack_err  out  1  one-cycle pulse on an illegal ack.
- drop_cnt  out  DROP_W  saturating count of requests lost to an already-set pending bit.

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, mask=MASK_RST, state=IDLE.
  - pend_vec=0, irq_valid=0, ack_err=0, drop_cnt=0.
  - Reset mid-handshake discards all pending bits. Any ack seen in the same cycle as reset release is ignored.
- Capture: for each bit i, pending[i] is set at the clock edge where req_in[i]=1 (level mode, see Optional Feature). Masked-off lines still set pending; the mask gates only pend_vec.
- pend_vec = pending & mask, from registers only. It updates the cycle after the capturing edge.
- Mask write: mask_we=1 loads mask_in at the edge. Unmasking a pending bit makes it visible on pend_vec the next cycle.
- FSM states: IDLE, VALID, SETTLE.
  - IDLE: irq_valid=0. Go to VALID when pend_vec != 0, so irq_valid rises one cycle after pend_vec.
  - VALID: irq_valid=1.
    - ack=1 and pend_vec[ack_idx]=1: clear pending[ack_idx], go to SETTLE.
    - ack=1 and pend_vec[ack_idx]=0: pulse ack_err, clear nothing, stay VALID.
    - pend_vec becomes 0 through a mask write with no ack: go to IDLE.
  - SETTLE: irq_valid=0 for exactly one cycle so the encoder output re-settles. Then go to VALID if pend_vec != 0, else IDLE.
- ack in IDLE or SETTLE: ignored, ack_err pulses.
- Simultaneous set and clear of the same bit (req_in[i]=1 in the ack cycle for i=ack_idx): set wins, bit stays pending, not counted as a drop.
- Drop: req_in[i]=1 while pending[i]=1 and not being cleared that cycle increments drop_cnt by 1.
  - Several bits dropping in one cycle still add only 1.
  - Saturates at all-ones; no wrap.
- The block never computes priority itself; it trusts ack_idx from the encoder.

Optional Feature:
- Macro REQ_EDGE_DETECT_EN.
- Defined:
  - A registered copy req_q of req_in is kept, reset to 0.
  - A bit captures only on a rising edge (req_in[i]=1 and req_q[i]=0).
  - A held-high line produces one capture and never counts as a drop after the first edge.
- Undefined: level capture as described above. A held-high line re-asserts every cycle and re-sets the bit immediately after an ack, with drop_cnt incrementing while pending.

Test Plan:
- Reset, then single pulse: req_in=8'h08 for 1 cycle -> pend_vec=8'h08 next cycle, irq_valid=1 one cycle later. ack=1, ack_idx=3 -> pend_vec=8'h00, one SETTLE cycle, then IDLE, drop_cnt=0.
- Multi-request: req_in=8'h88 pulse -> pend_vec=8'h88. ack_idx=7 -> pend_vec=8'h08, irq_valid low 1 cycle, then high. ack_idx=3 -> IDLE.
- Mask: mask_in=8'h0F with req 8'hF0 -> pend_vec=0, irq_valid=0. mask_in=8'hFF -> pend_vec=8'hF0, then irq_valid=1.
- Bad ack: pending 8'h02, ack_idx=5 in VALID -> ack_err pulses 1 cycle, pend_vec stays 8'h02. ack while IDLE -> ack_err pulses.
- Drop/saturation (DROP_W=8, level mode): hold req_in=8'h01 for 300 cycles without ack -> drop_cnt stops at 8'hFF. Async rst_n low mid-run -> all outputs 0 immediately.
- Edge mode (macro defined): hold req_in=8'h01 for 10 cycles, ack once -> pending cleared and not re-set, drop_cnt=0.
